// File: rtl/huff_enc_sched_pkg.sv
// Shared definitions for the Huffman encoder job scheduler: FSM states,
// response error codes, core I/O field positions and job helper functions.
package huff_enc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CORE_RST,
    LOAD,
    WAIT_DONE,
    CAPTURE,
    RESP
  } sched_state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
  localparam logic [1:0] ERR_DUP_SYM   = 2'b10;
  localparam logic [1:0] ERR_ZERO_FREQ = 2'b11;

  localparam int DONE_BIT  = 8;
  localparam int MASK_LSB  = 3;
  localparam int VAL_LSB   = 0;
  localparam int SYM_LSB   = 0;
  localparam int FREQ_LSB  = 8;
  localparam int CORE_IO_W = 12;

  // Symbols collide in the core when their low nibbles match, so that check wins.
  function automatic logic [1:0] job_check(input logic [3:0] n0,
                                           input logic [3:0] n1,
                                           input logic [3:0] n2,
                                           input logic [5:0] freq);
    if (n0 == n1 || n0 == n2 || n1 == n2) return ERR_DUP_SYM;
    if (freq[1:0] == 2'b00 || freq[3:2] == 2'b00 || freq[5:4] == 2'b00) return ERR_ZERO_FREQ;
    return ERR_OK;
  endfunction

  function automatic logic [CORE_IO_W-1:0] load_word(input logic [23:0] sym,
                                                     input logic [5:0]  freq,
                                                     input logic [1:0]  i);
    logic [CORE_IO_W-1:0] w;
    w = '0;
    case (i)
      2'd0: begin w[SYM_LSB +: 8] = sym[7:0];   w[FREQ_LSB +: 2] = freq[1:0]; end
      2'd1: begin w[SYM_LSB +: 8] = sym[15:8];  w[FREQ_LSB +: 2] = freq[3:2]; end
      2'd2: begin w[SYM_LSB +: 8] = sym[23:16]; w[FREQ_LSB +: 2] = freq[5:4]; end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/huff_enc_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Produces a one-hot grant and the matching index; all-zero grant when idle.
module huff_enc_sched_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx
);

  logic [IDW:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      cand = {1'b0, ptr} + (IDW+1)'(j);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (req[cand[IDW-1:0]]) begin
        grant                 = '0;
        grant[cand[IDW-1:0]]  = 1'b1;
        idx                   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/huff_enc_sched.sv
// Round-robin scheduler sharing one huff_encoder core between NUM_REQ requesters:
// validates a job, resets and loads the core, collects three code words, responds.
module huff_enc_sched
  import huff_enc_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 31,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*24-1:0]   req_sym,
  input  logic [NUM_REQ*6-1:0]    req_freq,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    core_reset,
  output logic [CORE_IO_W-1:0]    core_io_in,
  input  logic [CORE_IO_W-1:0]    core_io_out,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [8:0]              rsp_code,
  output logic [8:0]              rsp_mask,
  output logic [1:0]              rsp_err,
  input  logic                    rsp_ready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t        state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      job_id;
  logic [23:0]         sym_r;
  logic [5:0]          freq_r;
  logic [1:0]          idx;
  logic [TW-1:0]       tcnt;
  logic [5:0]          code_acc;
  logic [5:0]          mask_acc;

  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      gnt_idx;
  logic [1:0]          chk_err;
  logic                core_done;
  logic [2:0]          core_val;
  logic [2:0]          core_mask;
  logic                unused_io;

  huff_enc_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign chk_err   = job_check(sym_r[3:0], sym_r[11:8], sym_r[19:16], freq_r);
  assign core_done = core_io_out[DONE_BIT];
  assign core_val  = core_io_out[VAL_LSB +: 3];
  assign core_mask = core_io_out[MASK_LSB +: 3];
  assign unused_io = ^{core_io_out[11:9], core_io_out[7:6]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      job_id     <= '0;
      sym_r      <= '0;
      freq_r     <= '0;
      idx        <= '0;
      tcnt       <= '0;
      code_acc   <= '0;
      mask_acc   <= '0;
      req_ready  <= '0;
      core_reset <= 1'b1;
      core_io_in <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_code   <= '0;
      rsp_mask   <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          core_reset <= 1'b0;
          if (|req_valid) begin
            req_ready <= grant;
            job_id    <= gnt_idx;
            sym_r     <= req_sym[int'(gnt_idx)*24 +: 24];
            freq_r    <= req_freq[int'(gnt_idx)*6 +: 6];
            rr_ptr    <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            state     <= CHECK;
          end
        end

        CHECK: begin
          rsp_id <= job_id;
          if (chk_err != ERR_OK) begin
            // Malformed job: answer straight away, the core is left untouched.
            rsp_err   <= chk_err;
            rsp_code  <= '0;
            rsp_mask  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            core_reset <= 1'b1;
            core_io_in <= '0;
            state      <= CORE_RST;
          end
        end

        CORE_RST: begin
          core_reset <= 1'b0;
          core_io_in <= load_word(sym_r, freq_r, 2'd0);
          idx        <= 2'd0;
          state      <= LOAD;
        end

        LOAD: begin
          if (idx == 2'd2) begin
            core_io_in <= '0;
            tcnt       <= '0;
            state      <= WAIT_DONE;
          end else begin
            core_io_in <= load_word(sym_r, freq_r, idx + 2'd1);
            idx        <= idx + 2'd1;
          end
        end

        WAIT_DONE: begin
          if (core_done) begin
            code_acc[2:0] <= core_val;
            mask_acc[2:0] <= core_mask;
            idx           <= 2'd1;
            state         <= CAPTURE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_err   <= ERR_TIMEOUT;
            rsp_code  <= '0;
            rsp_mask  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        // Codes 1 and 2 follow code 0 on back-to-back cycles; done is not re-checked.
        CAPTURE: begin
          if (idx == 2'd1) begin
            code_acc[5:3] <= core_val;
            mask_acc[5:3] <= core_mask;
            idx           <= 2'd2;
          end else begin
            rsp_code  <= {core_val, code_acc};
            rsp_mask  <= {core_mask, mask_acc};
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_enc_sched.sv
// Bench for huff_enc_sched with a behavioural stub core and a job-level reference model.
module tb_huff_enc_sched;

  localparam int N   = 3;
  localparam int T   = 31;
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*24-1:0]   req_sym = '0;
  logic [N*6-1:0]    req_freq = '0;
  logic [N-1:0]      req_ready;
  logic              core_reset;
  logic [11:0]       core_io_in;
  logic [11:0]       core_io_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_code;
  logic [8:0]        rsp_mask;
  logic [1:0]        rsp_err;
  logic              rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Stub configuration (written by the stimulus) and observations (written by the stub).
  int          stub_d = 4;
  logic        stub_hang = 1'b0;
  logic [11:0] cw [4];
  int          k = 0;
  int          k_rsp = 0;
  int          rst_cycles = 0;
  int          io_busy = 0;
  logic [11:0] ld [3];
  logic        rsp_seen = 1'b0;

  int ptr_m = 0;
  int last_id;
  logic [8:0] last_code, last_mask;
  logic [1:0] last_err;

  huff_enc_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_sym    (req_sym),
    .req_freq   (req_freq),
    .req_ready  (req_ready),
    .core_reset (core_reset),
    .core_io_in (core_io_in),
    .core_io_out(core_io_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_code   (rsp_code),
    .rsp_mask   (rsp_mask),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  // Stub core: k counts cycles since its reset; k=1..3 are the load cycles,
  // done with word 0 appears stub_d cycles after loading, then words 1..3.
  always @(negedge clk) begin
    if (core_reset) begin
      k = 0;
      rst_cycles++;
    end else if (k < 1000000) begin
      k++;
    end
    if (core_io_in != 12'h000) io_busy++;
    if (k >= 1 && k <= 3) ld[k-1] = core_io_in;
    if (rsp_valid && !rsp_seen) k_rsp = k;
    rsp_seen = rsp_valid;
    if (!stub_hang && k == 3 + stub_d)      core_io_out = cw[0] | 12'h100;
    else if (!stub_hang && k == 4 + stub_d) core_io_out = cw[1];
    else if (!stub_hang && k == 5 + stub_d) core_io_out = cw[2];
    else if (!stub_hang && k == 6 + stub_d) core_io_out = cw[3];
    else                                    core_io_out = cw[3] & 12'hEFF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner(input logic [N-1:0] v, input int p);
    for (int j = 0; j < N; j++)
      if (v[(p + j) % N]) return (p + j) % N;
    return 0;
  endfunction

  function automatic logic [1:0] exp_err(input logic [23:0] s, input logic [5:0] f);
    logic [7:0] a, b, c;
    a = s[7:0]; b = s[15:8]; c = s[23:16];
    if (a[3:0] == b[3:0] || a[3:0] == c[3:0] || b[3:0] == c[3:0]) return 2'b10;
    if (f[1:0] == 2'd0 || f[3:2] == 2'd0 || f[5:4] == 2'd0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic set_job(input int i, input logic [23:0] s, input logic [5:0] f);
    req_sym[i*24 +: 24] = s;
    req_freq[i*6 +: 6]  = f;
    req_valid[i]        = 1'b1;
  endtask

  task automatic rand_job(input int i);
    logic [23:0] s;
    logic [5:0]  f;
    s = 24'($urandom);
    if ($urandom_range(0, 3) == 0) s[11:8] = s[19:16];
    for (int j = 0; j < 3; j++)
      f[2*j +: 2] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
    set_job(i, s, f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // Waits for a grant, predicts the whole response, holds rsp_ready low for
  // 'hold' cycles, then completes the handshake.
  task automatic serve(input int hold);
    int cyc, w, lat, rst0, io0;
    logic [23:0] s;
    logic [5:0]  f;
    logic [1:0]  e;
    logic [8:0]  ec, em;
    logic [63:0] snap;
    rst0 = rst_cycles;
    io0  = io_busy;
    cyc  = 0;
    while (req_ready == '0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("grant_seen", 64'(req_ready != '0), 64'd1);
    if (req_ready == '0) return;
    w = exp_winner(req_valid, ptr_m);
    chk("grant_onehot", 64'(req_ready), 64'd1 << w);
    s = req_sym[w*24 +: 24];
    f = req_freq[w*6 +: 6];
    req_valid[w] = 1'b0;
    ptr_m = (w + 1) % N;
    e = exp_err(s, f);
    if (e == 2'b00 && stub_hang) e = 2'b01;
    ec = (e == 2'b00) ? {cw[2][2:0], cw[1][2:0], cw[0][2:0]} : 9'd0;
    em = (e == 2'b00) ? {cw[2][5:3], cw[1][5:3], cw[0][5:3]} : 9'd0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
    if (!rsp_valid) return;
    chk("rsp_id", 64'(rsp_id), 64'(w));
    chk("rsp_err", 64'(rsp_err), 64'(e));
    chk("rsp_code", 64'(rsp_code), 64'(ec));
    chk("rsp_mask", 64'(rsp_mask), 64'(em));
    last_id = int'(rsp_id); last_code = rsp_code; last_mask = rsp_mask; last_err = rsp_err;
    if (e[1]) begin
      chk("err_latency", 64'(lat), 64'd1);
      chk("err_no_core_rst", 64'(rst_cycles - rst0), 64'd0);
      chk("err_no_core_io", 64'(io_busy - io0), 64'd0);
    end else begin
      chk("core_words", {28'd0, ld[2], ld[1], ld[0]},
          {28'd0, 2'b00, f[5:4], s[23:16], 2'b00, f[3:2], s[15:8], 2'b00, f[1:0], s[7:0]});
    end
    snap = {37'd0, 1'b1, rsp_id, rsp_code, rsp_mask, rsp_err};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", {37'd0, rsp_valid, rsp_id, rsp_code, rsp_mask, rsp_err}, snap);
      chk("hold_no_grant", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", 64'(rsp_valid), 64'd0);
    if (!e[1]) chk("rsp_latency", 64'(k_rsp), e[0] ? 64'(4 + T) : 64'(6 + stub_d));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int j = 0; j < 4; j++) cw[j] = 12'h000;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {24'd0, req_ready, rsp_valid, rsp_id, rsp_code, rsp_mask, rsp_err, core_io_in, core_reset},
        64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_core_reset_low", 64'(core_reset), 64'd0);

    // Single job with the reference core words.
    cw[0] = 12'h11A; cw[1] = 12'h108; cw[2] = 12'h137; cw[3] = 12'h1FF; stub_d = 4;
    set_job(0, 24'h636261, {2'd3, 2'd2, 2'd1});
    serve(0);
    chk("job1_code", 64'(last_code), 64'(9'b111_000_010));
    chk("job1_mask", 64'(last_mask), 64'(9'b110_001_011));
    chk("job1_loads", {28'd0, ld[2], ld[1], ld[0]}, {28'd0, 12'h363, 12'h262, 12'h161});

    // Two requesters at once from rr_ptr=0, then req0 again back-to-back.
    do_reset();
    set_job(0, 24'h030201, 6'b010101);
    set_job(1, 24'h141312, 6'b101010);
    serve(0);
    chk("order_first", 64'(last_id), 64'd0);
    set_job(0, 24'h252423, 6'b111111);
    serve(0);
    chk("order_second", 64'(last_id), 64'd1);
    serve(0);
    chk("order_third", 64'(last_id), 64'd0);

    // Malformed jobs.
    set_job(0, 24'h637161, 6'b010101);
    serve(0);
    chk("dup_err", 64'(last_err), 64'd2);
    set_job(0, 24'h332211, {2'd1, 2'd0, 2'd2});
    serve(0);
    chk("zero_err", 64'(last_err), 64'd3);
    set_job(0, 24'h636161, 6'b000000);
    serve(0);
    chk("dup_priority", 64'(last_err), 64'd2);

    // Hung core.
    stub_hang = 1'b1;
    set_job(1, 24'h0C0B0A, 6'b011011);
    serve(0);
    chk("timeout_err", 64'(last_err), 64'd1);
    stub_hang = 1'b0;

    // Reset while loading symbol 1.
    req_valid = '0;
    set_job(2, 24'h3D2C1B, {2'd1, 2'd2, 2'd3});
    cyc = 0;
    while (req_ready == '0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("midrst_grant", 64'(req_ready), 64'd4);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_in_load1", 64'(core_io_in), 64'h22C);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outputs",
        {24'd0, req_ready, rsp_valid, rsp_id, rsp_code, rsp_mask, rsp_err, core_io_in, core_reset},
        64'd1);
    reset = 1'b0;
    ptr_m = 0;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      chk("midrst_quiet", {62'd0, rsp_valid, |req_ready}, 64'd0);
    end
    stub_d = 2;
    cw[0] = 12'h02D; cw[1] = 12'h0F1; cw[2] = 12'h3AE; cw[3] = 12'h555;
    set_job(1, 24'h0F0E0D, 6'b101101);
    serve(0);

    // Stalled consumer with other requesters pending.
    set_job(0, 24'h474645, 6'b111001);
    set_job(2, 24'h8A8988, 6'b011110);
    serve(5);
    serve(0);

    // Randomised jobs.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_job(i);
      if (req_valid == '0) rand_job(int'($urandom_range(0, N - 1)));
      stub_d    = int'($urandom_range(1, 6));
      stub_hang = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 4; j++) cw[j] = 12'($urandom);
      serve(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
